// File: rtl/spi_slave_fe.sv
// spi_slave_fe: SPI slave front-end for the single-port RAM stage.
// Deserialises 10-bit command words from MOSI, returns RAM read data on MISO.
module spi_slave_fe #(
    parameter int IN_WIDTH  = 10,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [IN_WIDTH-1:0]  rx_data,
    output logic                 rx_valid,
    input  logic [OUT_WIDTH-1:0] tx_data,
    input  logic                 tx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Sub-phase inside WRITE / READ_ADD / READ_DATA.
    // PH_DONE is the "word finished, wait for SS_n" hold.
    typedef enum logic [1:0] {
        PH_RX,
        PH_WAIT_TX,
        PH_TX,
        PH_DONE
    } phase_t;

    localparam logic [3:0] RX_LAST = 4'(IN_WIDTH - 2);
    localparam logic [3:0] TX_LAST = 4'(OUT_WIDTH - 1);

    state_t               state, state_nxt;
    phase_t               phase, phase_nxt;
    logic [3:0]           rx_cnt, rx_cnt_nxt;
    logic [3:0]           tx_cnt, tx_cnt_nxt;
    logic [IN_WIDTH-2:0]  rx_shift, rx_shift_nxt;
    logic [OUT_WIDTH-1:0] tx_shift, tx_shift_nxt;
    logic [IN_WIDTH-1:0]  rx_data_nxt;
    logic                 rx_valid_nxt;
    logic                 miso_nxt;
    logic                 rd_addr_flag, flag_nxt;
    logic                 in_frame;
    logic                 last_bit;

    assign in_frame = (state == WRITE) || (state == READ_ADD)
                   || (state == READ_DATA);

    // The final word bit is taken even if SS_n rises on the same edge.
    assign last_bit = in_frame && (phase == PH_RX) && (rx_cnt == RX_LAST);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        rx_cnt_nxt   = rx_cnt;
        tx_cnt_nxt   = tx_cnt;
        rx_shift_nxt = rx_shift;
        tx_shift_nxt = tx_shift;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        miso_nxt     = 1'b0;
        flag_nxt     = rd_addr_flag;

        if ((state != IDLE) && SS_n && !last_bit) begin
            state_nxt    = IDLE;
            phase_nxt    = PH_RX;
            rx_cnt_nxt   = '0;
            tx_cnt_nxt   = '0;
            rx_shift_nxt = '0;
            tx_shift_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!SS_n) begin
                        state_nxt  = CHK_CMD;
                        phase_nxt  = PH_RX;
                        rx_cnt_nxt = '0;
                        tx_cnt_nxt = '0;
                    end
                end
                CHK_CMD: begin
                    rx_shift_nxt = {{(IN_WIDTH-2){1'b0}}, MOSI};
                    rx_cnt_nxt   = '0;
                    phase_nxt    = PH_RX;
                    if (!MOSI)
                        state_nxt = WRITE;
                    else if (!rd_addr_flag)
                        state_nxt = READ_ADD;
                    else
                        state_nxt = READ_DATA;
                end
                default: begin
                    unique case (phase)
                        PH_RX: begin
                            rx_shift_nxt = {rx_shift[IN_WIDTH-3:0], MOSI};
                            rx_cnt_nxt   = rx_cnt + 4'd1;
                            if (last_bit) begin
                                rx_data_nxt  = {rx_shift, MOSI};
                                rx_valid_nxt = 1'b1;
                                rx_cnt_nxt   = '0;
                                rx_shift_nxt = '0;
                                if (state == READ_ADD)
                                    flag_nxt = 1'b1;
                                phase_nxt = (state == READ_DATA)
                                          ? PH_WAIT_TX : PH_DONE;
                                if (SS_n) begin
                                    state_nxt = IDLE;
                                    phase_nxt = PH_RX;
                                end
                            end
                        end
                        PH_WAIT_TX: begin
                            if (tx_valid) begin
                                miso_nxt     = tx_data[OUT_WIDTH-1];
                                tx_shift_nxt = {tx_data[OUT_WIDTH-2:0], 1'b0};
                                tx_cnt_nxt   = '0;
                                phase_nxt    = PH_TX;
                            end
                        end
                        PH_TX: begin
                            if (tx_cnt == TX_LAST) begin
                                flag_nxt   = 1'b0;
                                tx_cnt_nxt = '0;
                                phase_nxt  = PH_DONE;
                            end else begin
                                miso_nxt     = tx_shift[OUT_WIDTH-1];
                                tx_shift_nxt = {tx_shift[OUT_WIDTH-2:0], 1'b0};
                                tx_cnt_nxt   = tx_cnt + 4'd1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            endcase
        end
    end

    // State, counters, shift registers and outputs; reset dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= PH_RX;
            rx_cnt       <= '0;
            tx_cnt       <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            MISO         <= 1'b0;
            rd_addr_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase        <= phase_nxt;
            rx_cnt       <= rx_cnt_nxt;
            tx_cnt       <= tx_cnt_nxt;
            rx_shift     <= rx_shift_nxt;
            tx_shift     <= tx_shift_nxt;
            rx_data      <= rx_data_nxt;
            rx_valid     <= rx_valid_nxt;
            MISO         <= miso_nxt;
            rd_addr_flag <= flag_nxt;
        end
    end

endmodule
